// File: rtl/am2901_pkg.sv
// Shared encodings for the Am2901 command sequencer: microcode fields,
// host opcodes, the safe idle word and the FSM state type.
package am2901_pkg;

  typedef enum logic [2:0] {
    SRC_AQ = 3'd0,
    SRC_AB = 3'd1,
    SRC_ZQ = 3'd2,
    SRC_ZB = 3'd3,
    SRC_ZA = 3'd4,
    SRC_DA = 3'd5,
    SRC_DQ = 3'd6,
    SRC_DZ = 3'd7
  } src_e;

  typedef enum logic [2:0] {
    FN_ADD   = 3'd0,
    FN_SUBR  = 3'd1,
    FN_SUBS  = 3'd2,
    FN_OR    = 3'd3,
    FN_AND   = 3'd4,
    FN_NOTRS = 3'd5,
    FN_EXOR  = 3'd6,
    FN_EXNOR = 3'd7
  } func_e;

  typedef enum logic [2:0] {
    DST_QREG  = 3'd0,
    DST_NOP   = 3'd1,
    DST_RAMA  = 3'd2,
    DST_RAMF  = 3'd3,
    DST_RAMQD = 3'd4,
    DST_RAMD  = 3'd5,
    DST_RAMQU = 3'd6,
    DST_RAMU  = 3'd7
  } dest_e;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_MOV = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_ADC = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_CLR = 4'd11;
  localparam logic [3:0] OP_OUT = 4'd12;

  // dest NOP, func OR, src DZ with D = 0: touches neither RAM nor Q
  localparam logic [8:0] NOP_WORD = 9'h05F;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    dest_e dest;
    func_e func;
    src_e  src;
    logic  cin;
    logic  oe_n;
    logic  sh_en;
    logic  fill;
    logic  use_d;
    logic  upd_flags;
    logic  is_shift;
  } uop_t;

  function automatic logic [8:0] uop_word(input uop_t u);
    return {u.dest, u.func, u.src};
  endfunction

endpackage

// File: rtl/am2901_uop_decode.sv
// Combinational opcode-to-microinstruction map; the carry input of ADC
// comes from the sequencer's stored cout flag.
module am2901_uop_decode
  import am2901_pkg::*;
(
  input  logic [3:0] op,
  input  logic       cout_q,
  output uop_t       uop
);

  always_comb begin
    uop.dest      = DST_NOP;
    uop.func      = FN_OR;
    uop.src       = SRC_DZ;
    uop.cin       = 1'b0;
    uop.oe_n      = 1'b1;
    uop.sh_en     = 1'b0;
    uop.fill      = 1'b0;
    uop.use_d     = 1'b0;
    uop.upd_flags = 1'b1;
    uop.is_shift  = 1'b0;
    case (op)
      OP_LDI: begin
        uop.dest  = DST_RAMF;
        uop.use_d = 1'b1;
      end
      OP_MOV: begin
        uop.dest = DST_RAMF;
        uop.src  = SRC_ZA;
      end
      OP_ADD: begin
        uop.dest = DST_RAMF;
        uop.func = FN_ADD;
        uop.src  = SRC_AB;
      end
      OP_ADC: begin
        uop.dest = DST_RAMF;
        uop.func = FN_ADD;
        uop.src  = SRC_AB;
        uop.cin  = cout_q;
      end
      OP_SUB: begin
        // SUBR computes S - R = B + ~A + 1
        uop.dest = DST_RAMF;
        uop.func = FN_SUBR;
        uop.src  = SRC_AB;
        uop.cin  = 1'b1;
      end
      OP_AND: begin
        uop.dest = DST_RAMF;
        uop.func = FN_AND;
        uop.src  = SRC_AB;
      end
      OP_OR: begin
        uop.dest = DST_RAMF;
        uop.src  = SRC_AB;
      end
      OP_XOR: begin
        uop.dest = DST_RAMF;
        uop.func = FN_EXOR;
        uop.src  = SRC_AB;
      end
      OP_SHL: begin
        uop.dest     = DST_RAMU;
        uop.src      = SRC_ZB;
        uop.sh_en    = 1'b1;
        uop.is_shift = 1'b1;
      end
      OP_SHR: begin
        uop.dest     = DST_RAMD;
        uop.src      = SRC_ZB;
        uop.sh_en    = 1'b1;
        uop.is_shift = 1'b1;
      end
      OP_CLR: begin
        uop.dest = DST_RAMF;
        uop.func = FN_AND;
        uop.src  = SRC_ZA;
      end
      OP_OUT: begin
        uop.src  = SRC_ZA;
        uop.oe_n = 1'b0;
      end
      default: begin
        // NOP and the unused opcodes 13..15 leave the slice and flags alone
        uop.upd_flags = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/am2901_seq.sv
// Command sequencer for one Am2901 slice: accepts host commands over
// valid/ready and drives registered microinstructions onto the slice.
module am2901_seq
  import am2901_pkg::*;
#(
  parameter int RPT_W = 2
) (
  input  logic             cp,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [3:0]       cmd_imm,
  input  logic [RPT_W-1:0] cmd_cnt,
  output logic             done,
  output logic [3:0]       flags,
  output logic [8:0]       alu_i,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_d,
  output logic             alu_cin,
  output logic             alu_oe,
  output logic             ram_sh_en,
  output logic             ram0_o,
  output logic             ram3_o,
  input  logic             alu_cout,
  input  logic             alu_ovr,
  input  logic             alu_z,
  input  logic             alu_f3
);

  localparam logic [RPT_W-1:0] CNT_ONE = RPT_W'(1);

  state_e           state_q, state_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  logic             upd_q;
  logic             load, finish;
  uop_t             uop;

  am2901_uop_decode u_dec (
    .op     (cmd_op),
    .cout_q (flags[3]),
    .uop    (uop)
  );

  assign cmd_ready = (state_q == ST_IDLE);

  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q holds the number of steps still to run after the current one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_EXEC;
          load    = 1'b1;
          cnt_d   = uop.is_shift ? cmd_cnt : '0;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Slice control word: loaded on acceptance, held for every step, and
  // returned to the safe idle word at the edge that ends the last step.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      alu_i     <= NOP_WORD;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_d     <= '0;
      alu_cin   <= 1'b0;
      alu_oe    <= 1'b1;
      ram_sh_en <= 1'b0;
      ram0_o    <= 1'b0;
      ram3_o    <= 1'b0;
      upd_q     <= 1'b0;
      done      <= 1'b0;
      flags     <= '0;
    end else begin
      done <= finish;
      if (load) begin
        alu_i     <= uop_word(uop);
        alu_a     <= cmd_a;
        alu_b     <= cmd_b;
        alu_d     <= uop.use_d ? cmd_imm : 4'd0;
        alu_cin   <= uop.cin;
        alu_oe    <= uop.oe_n;
        ram_sh_en <= uop.sh_en;
        ram0_o    <= uop.fill;
        ram3_o    <= uop.fill;
        upd_q     <= uop.upd_flags;
      end else if (finish) begin
        alu_i     <= NOP_WORD;
        alu_a     <= '0;
        alu_b     <= '0;
        alu_d     <= '0;
        alu_cin   <= 1'b0;
        alu_oe    <= 1'b1;
        ram_sh_en <= 1'b0;
        ram0_o    <= 1'b0;
        ram3_o    <= 1'b0;
        upd_q     <= 1'b0;
        if (upd_q) flags <= {alu_cout, alu_ovr, alu_z, alu_f3};
      end
    end
  end

endmodule

// File: tb/tb_am2901_seq.sv
// Bench for am2901_seq: a behavioural Am2901 slice reacts to the sequencer,
// and a done-driven scoreboard checks flags and register contents.
module tb_am2901_seq;

  logic       cp = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'd0, cmd_a = 4'd0, cmd_b = 4'd0, cmd_imm = 4'd0;
  logic [1:0] cmd_cnt = 2'd0;
  logic       done;
  logic [3:0] flags;
  logic [8:0] alu_i;
  logic [3:0] alu_a, alu_b, alu_d;
  logic       alu_cin, alu_oe, ram_sh_en, ram0_o, ram3_o;
  logic       alu_cout, alu_ovr, alu_z, alu_f3;

  am2901_seq #(.RPT_W(2)) dut (
    .cp(cp), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_imm(cmd_imm),
    .cmd_cnt(cmd_cnt), .done(done), .flags(flags), .alu_i(alu_i),
    .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d), .alu_cin(alu_cin),
    .alu_oe(alu_oe), .ram_sh_en(ram_sh_en), .ram0_o(ram0_o), .ram3_o(ram3_o),
    .alu_cout(alu_cout), .alu_ovr(alu_ovr), .alu_z(alu_z), .alu_f3(alu_f3)
  );

  always #5 cp = ~cp;

  // Behavioural Am2901 slice
  logic [3:0] m_ram [16];
  logic [3:0] m_q = 4'd0;
  logic [3:0] m_r, m_s, m_f, ra, rb, y;
  logic [4:0] m_sum;
  logic [3:0] m_lo;
  logic       m_arith, fill0, fill3;

  // an undriven shift-fill line floats high
  assign fill0 = ram_sh_en ? ram0_o : 1'b1;
  assign fill3 = ram_sh_en ? ram3_o : 1'b1;

  always_comb begin
    ra = m_ram[alu_a];
    rb = m_ram[alu_b];
    case (alu_i[2:0])
      3'd0:    begin m_r = ra;    m_s = m_q;  end
      3'd1:    begin m_r = ra;    m_s = rb;   end
      3'd2:    begin m_r = 4'd0;  m_s = m_q;  end
      3'd3:    begin m_r = 4'd0;  m_s = rb;   end
      3'd4:    begin m_r = 4'd0;  m_s = ra;   end
      3'd5:    begin m_r = alu_d; m_s = ra;   end
      3'd6:    begin m_r = alu_d; m_s = m_q;  end
      default: begin m_r = alu_d; m_s = 4'd0; end
    endcase
    m_sum = 5'd0;
    m_lo = 4'd0;
    m_arith = 1'b0;
    m_f = 4'd0;
    case (alu_i[5:3])
      3'd0: begin
        m_arith = 1'b1;
        m_sum = {1'b0, m_r} + {1'b0, m_s} + {4'd0, alu_cin};
        m_lo = {1'b0, m_r[2:0]} + {1'b0, m_s[2:0]} + {3'd0, alu_cin};
      end
      3'd1: begin
        m_arith = 1'b1;
        m_sum = {1'b0, ~m_r} + {1'b0, m_s} + {4'd0, alu_cin};
        m_lo = {1'b0, ~m_r[2:0]} + {1'b0, m_s[2:0]} + {3'd0, alu_cin};
      end
      3'd2: begin
        m_arith = 1'b1;
        m_sum = {1'b0, m_r} + {1'b0, ~m_s} + {4'd0, alu_cin};
        m_lo = {1'b0, m_r[2:0]} + {1'b0, ~m_s[2:0]} + {3'd0, alu_cin};
      end
      3'd3:    m_f = m_r | m_s;
      3'd4:    m_f = m_r & m_s;
      3'd5:    m_f = ~m_r & m_s;
      3'd6:    m_f = m_r ^ m_s;
      default: m_f = ~(m_r ^ m_s);
    endcase
    if (m_arith) m_f = m_sum[3:0];
    alu_cout = m_arith & m_sum[4];
    alu_ovr  = m_arith & (m_sum[4] ^ m_lo[3]);
    alu_z    = (m_f == 4'd0);
    alu_f3   = m_f[3];
    y        = (alu_i[8:6] == 3'd2) ? ra : m_f;
  end

  always @(posedge cp) begin
    case (alu_i[8:6])
      3'd0: m_q <= m_f;
      3'd2, 3'd3: m_ram[alu_b] <= m_f;
      3'd4: begin m_ram[alu_b] <= {fill3, m_f[3:1]}; m_q <= {1'b0, m_q[3:1]}; end
      3'd5: m_ram[alu_b] <= {fill3, m_f[3:1]};
      3'd6: begin m_ram[alu_b] <= {m_f[2:0], fill0}; m_q <= {m_q[2:0], 1'b0}; end
      3'd7: m_ram[alu_b] <= {m_f[2:0], fill0};
      default: ;
    endcase
  end

  // Scoreboard
  typedef struct packed {
    logic [3:0] flg;
    logic       rchk;
    logic [3:0] ridx;
    logic [3:0] rval;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge cp) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("done_unexpected", 16'(done), 16'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("flags", 16'(flags), 16'(mon_e.flg));
        if (mon_e.rchk) chk("reg", 16'(m_ram[mon_e.ridx]), 16'(mon_e.rval));
      end
    end
  end

  // Drive a command, wait for the handshake, push its expectation; returns
  // 1 time unit into the first EXEC cycle.
  task automatic send(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] imm, input logic [1:0] cnt, input logic keep,
                      input logic [3:0] ef, input logic rchk, input logic [3:0] ridx,
                      input logic [3:0] rval);
    int   g;
    exp_t e;
    @(negedge cp);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_imm = imm; cmd_cnt = cnt;
    cmd_valid = 1'b1;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 40) begin
      @(negedge cp);
      g++;
    end
    chk("hs_ready", 16'(cmd_ready), 16'd1);
    e.flg = ef; e.rchk = rchk; e.ridx = ridx; e.rval = rval;
    sb.push_back(e);
    @(posedge cp);
    #1;
    if (!keep) cmd_valid = 1'b0;
    chk("exec_busy", 16'(cmd_ready), 16'd0);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 60) begin
      @(posedge cp);
      g++;
    end
    #1;
    chk("drain", 16'(sb.size()), 16'd0);
  endtask

  // Count EXEC cycles (ready low) and shift-enable cycles until done.
  task automatic watch(output int ex_n, output int sh_n);
    int g;
    ex_n = 0; sh_n = 0; g = 0;
    @(negedge cp);
    while (done !== 1'b1 && g < 40) begin
      if (cmd_ready === 1'b0) ex_n++;
      if (ram_sh_en === 1'b1) sh_n++;
      @(negedge cp);
      g++;
    end
    chk("watch_done", 16'(done), 16'd1);
  endtask

  localparam logic [3:0] LDI = 4'd1, MOV = 4'd2, ADD = 4'd3, ADC = 4'd4, SUB = 4'd5;
  localparam logic [3:0] ANDO = 4'd6, ORO = 4'd7, XORO = 4'd8, SHL = 4'd9, SHR = 4'd10;
  localparam logic [3:0] CLR = 4'd11, OUTO = 4'd12;

  initial begin
    int ex, sh, base;
    #1 rst_n = 1'b0;
    #12;
    chk("rst_alu_i", 16'(alu_i), 16'h05F);
    chk("rst_ready", 16'(cmd_ready), 16'd1);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_flags", 16'(flags), 16'd0);
    chk("rst_abd", 16'({alu_a, alu_b, alu_d}), 16'd0);
    chk("rst_misc", 16'({alu_cin, alu_oe, ram_sh_en, ram0_o, ram3_o}), 16'b01000);
    @(negedge cp);
    rst_n = 1'b1;

    // load then read back through Y
    send(LDI, 4'd0, 4'd3, 4'hA, 2'd0, 1'b0, 4'b0001, 1'b1, 4'd3, 4'hA);
    wait_idle();
    send(OUTO, 4'd3, 4'd0, 4'd0, 2'd0, 1'b0, 4'b0001, 1'b0, 4'd0, 4'd0);
    chk("out_oe", 16'(alu_oe), 16'd0);
    chk("out_y", 16'(y), 16'hA);
    wait_idle();
    chk("out_z", 16'(flags[1]), 16'd0);
    chk("idle_oe", 16'(alu_oe), 16'd1);

    // add with carry out and zero, then add-with-carry
    send(LDI, 4'd0, 4'd1, 4'hF, 2'd0, 1'b0, 4'b0001, 1'b1, 4'd1, 4'hF);
    send(LDI, 4'd0, 4'd2, 4'h1, 2'd0, 1'b0, 4'b0000, 1'b1, 4'd2, 4'h1);
    send(ADD, 4'd1, 4'd2, 4'd0, 2'd0, 1'b0, 4'b1010, 1'b1, 4'd2, 4'h0);
    send(ADC, 4'd2, 4'd2, 4'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 4'd2, 4'h1);
    wait_idle();

    // shifts
    send(LDI, 4'd0, 4'd4, 4'h3, 2'd0, 1'b0, 4'b0000, 1'b1, 4'd4, 4'h3);
    send(SHL, 4'd0, 4'd4, 4'd0, 2'd1, 1'b0, 4'b0000, 1'b1, 4'd4, 4'hC);
    watch(ex, sh);
    chk("shl_exec", 16'(ex), 16'd2);
    chk("shl_sh_en", 16'(sh), 16'd2);
    send(SHR, 4'd0, 4'd4, 4'd0, 2'd3, 1'b0, 4'b0000, 1'b1, 4'd4, 4'h0);
    watch(ex, sh);
    chk("shr_exec", 16'(ex), 16'd4);
    wait_idle();

    // subtract, then NOP and an illegal opcode keep the flags
    send(LDI, 4'd0, 4'd5, 4'h2, 2'd0, 1'b0, 4'b0000, 1'b1, 4'd5, 4'h2);
    send(LDI, 4'd0, 4'd6, 4'h7, 2'd0, 1'b0, 4'b0000, 1'b1, 4'd6, 4'h7);
    send(SUB, 4'd5, 4'd6, 4'd0, 2'd0, 1'b0, 4'b1000, 1'b1, 4'd6, 4'h5);
    send(4'd14, 4'd5, 4'd6, 4'd0, 2'd3, 1'b0, 4'b1000, 1'b1, 4'd6, 4'h5);
    chk("ill_alu_i", 16'(alu_i), 16'h05F);
    watch(ex, sh);
    chk("ill_exec", 16'(ex), 16'd1);
    send(4'd0, 4'd5, 4'd6, 4'd0, 2'd0, 1'b0, 4'b1000, 1'b1, 4'd6, 4'h5);
    wait_idle();

    // valid held high across three commands
    base = done_cnt;
    send(LDI, 4'd0, 4'd8, 4'h9, 2'd0, 1'b1, 4'b0001, 1'b1, 4'd8, 4'h9);
    send(ANDO, 4'd8, 4'd3, 4'd0, 2'd0, 1'b1, 4'b0001, 1'b1, 4'd3, 4'h8);
    send(XORO, 4'd8, 4'd8, 4'd0, 2'd0, 1'b0, 4'b0010, 1'b1, 4'd8, 4'h0);
    wait_idle();
    chk("hs_dones", 16'(done_cnt - base), 16'd3);

    send(CLR, 4'd0, 4'd6, 4'd0, 2'd0, 1'b0, 4'b0010, 1'b1, 4'd6, 4'h0);
    send(ORO, 4'd5, 4'd4, 4'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 4'd4, 4'h2);
    send(MOV, 4'd5, 4'd9, 4'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 4'd9, 4'h2);
    wait_idle();

    // a valid pulse while busy is dropped; four shifts push bit 0 out
    send(LDI, 4'd0, 4'd7, 4'h0, 2'd0, 1'b0, 4'b0010, 1'b1, 4'd7, 4'h0);
    send(LDI, 4'd0, 4'd10, 4'h1, 2'd0, 1'b0, 4'b0000, 1'b1, 4'd10, 4'h1);
    wait_idle();
    base = done_cnt;
    send(SHL, 4'd0, 4'd10, 4'd0, 2'd3, 1'b0, 4'b0001, 1'b1, 4'd10, 4'h0);
    @(negedge cp);
    cmd_op = LDI; cmd_b = 4'd7; cmd_imm = 4'h5; cmd_valid = 1'b1;
    @(negedge cp);
    cmd_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge cp);
    chk("busy_r7", 16'(m_ram[7]), 16'h0);
    chk("busy_dones", 16'(done_cnt - base), 16'd1);

    // asynchronous reset during the second shift step
    send(LDI, 4'd0, 4'd11, 4'h3, 2'd0, 1'b0, 4'b0000, 1'b1, 4'd11, 4'h3);
    send(LDI, 4'd0, 4'd12, 4'hF, 2'd0, 1'b0, 4'b0001, 1'b1, 4'd12, 4'hF);
    wait_idle();
    base = done_cnt;
    send(SHL, 4'd0, 4'd11, 4'd0, 2'd3, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd0);
    @(posedge cp);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alu_i", 16'(alu_i), 16'h05F);
    chk("arst_ready", 16'(cmd_ready), 16'd1);
    chk("arst_flags", 16'(flags), 16'd0);
    chk("arst_sh_en", 16'(ram_sh_en), 16'd0);
    sb.delete();
    repeat (2) @(negedge cp);
    rst_n = 1'b1;
    repeat (6) @(negedge cp);
    chk("arst_no_done", 16'(done_cnt - base), 16'd0);
    chk("arst_r11", 16'(m_ram[11]), 16'h6);
    send(LDI, 4'd0, 4'd13, 4'h5, 2'd0, 1'b0, 4'b0000, 1'b1, 4'd13, 4'h5);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
